credit_sender: RTL



---
 rtl/credit_sender.sv | 100 ++++++++++
 1 files changed

// File: rtl/credit_sender.sv
// Sender end of a credit-based link: ready/valid producer side in, credit-gated
// registered link side out, with a sender-side credit counter and reset handshake.
module credit_sender #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_CREDITS = 4,
    localparam int unsigned CW         = $clog2(MAX_CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,

    output logic             push_ready,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,

    output logic             pop_sender_in_reset,
    input  logic             pop_receiver_in_reset,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_credit,

    input  logic [CW-1:0]    credit_initial,
    input  logic [CW-1:0]    credit_withhold,
    output logic [CW-1:0]    credit_count,
    output logic [CW-1:0]    credit_available,
    output logic             credit_overflow
);

    localparam logic [CW-1:0] MAX_CW = CW'(MAX_CREDITS);

    logic             in_reset_c;
    logic             fire_c;
    logic [CW-1:0]    credit_init_c;
    logic [CW-1:0]    credit_available_c;

    logic [CW-1:0]    credit_count_q,    credit_count_d;
    logic             pop_valid_q,       pop_valid_d;
    logic [WIDTH-1:0] pop_data_q,        pop_data_d;
    logic             credit_overflow_q, credit_overflow_d;

    // Either end being in reset re-initialises the link state.
    assign in_reset_c    = rst | pop_receiver_in_reset;
    assign credit_init_c = (credit_initial > MAX_CW) ? MAX_CW : credit_initial;

    // Usable credit saturates at zero when the withheld amount covers the count.
    assign credit_available_c = (credit_count_q > credit_withhold)
                              ? (credit_count_q - credit_withhold)
                              : '0;

    assign push_ready = !in_reset_c && (credit_available_c != '0);
    assign fire_c     = push_valid & push_ready;

    // Next-state for the credit counter, link register and overflow flag.
    always_comb begin
        credit_count_d    = credit_count_q;
        pop_valid_d       = 1'b0;
        pop_data_d        = pop_data_q;
        credit_overflow_d = credit_overflow_q;

        if (in_reset_c) begin
            credit_count_d = credit_init_c;
            pop_data_d     = '0;
        end else begin
            pop_valid_d = fire_c;
            if (fire_c) begin
                pop_data_d = push_data;
            end
            if (fire_c && !pop_credit) begin
                credit_count_d = credit_count_q - CW'(1);
            end else if (!fire_c && pop_credit) begin
                if (credit_count_q == MAX_CW) begin
                    credit_overflow_d = 1'b1;
                end else begin
                    credit_count_d = credit_count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_count_q    <= credit_init_c;
            pop_valid_q       <= 1'b0;
            pop_data_q        <= '0;
            credit_overflow_q <= 1'b0;
        end else begin
            credit_count_q    <= credit_count_d;
            pop_valid_q       <= pop_valid_d;
            pop_data_q        <= pop_data_d;
            credit_overflow_q <= credit_overflow_d;
        end
    end

    assign pop_sender_in_reset = rst;
    assign pop_valid           = pop_valid_q;
    assign pop_data            = pop_data_q;
    assign credit_count        = credit_count_q;
    assign credit_available    = credit_available_c;
    assign credit_overflow     = credit_overflow_q;

endmodule
